cons_cell_port: RTL and testbench

- Memory-side initiator that drives the memory controller's post-boot interface (write_enable/addr/write_data/read_data) on behalf of the evaluator.
- Turns one cell-level request (read or write a cons cell) into the two word accesses the RAM needs, with valid/ready handshakes on both request and response.
- Holds off all traffic until the controller reports boot complete.
- Cell layout: the cell at even address A has car at word A and cdr at word A+1.

---
 rtl/cons_mem_pkg.sv | 23 ++
 rtl/cons_cell_port.sv | 141 ++++++++++++++
 tb/tb_cons_cell_port.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cons_mem_pkg.sv
// Shared types for the cons-cell memory port: request opcodes and FSM states.
// A cons cell occupies CELL_WORDS consecutive words starting at an even address.
package cons_mem_pkg;

  localparam int CELL_WORDS = 2;

  typedef enum logic {
    CELL_READ  = 1'b0,
    CELL_WRITE = 1'b1
  } cell_op_t;

  typedef enum logic [2:0] {
    WAIT_BOOT,
    IDLE,
    RD_CAR,
    RD_CDR,
    RD_CAP,
    WR_CAR,
    WR_CDR,
    RESP
  } cell_port_state_t;

endpackage

// File: rtl/cons_cell_port.sv
// Evaluator-side initiator: turns one cons-cell read/write into two word accesses
// on the memory controller's post-boot interface, gated until boot completes.
module cons_cell_port
  import cons_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_boot_done,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_car,
  input  logic [DATA_WIDTH-1:0] req_cdr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_car,
  output logic [DATA_WIDTH-1:0] rsp_cdr,
  output logic                  busy
);

  cell_port_state_t      r_state;
  cell_port_state_t      w_next_state;
  logic                  r_boot_seen;
  cell_op_t              r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_car;
  logic [DATA_WIDTH-1:0] r_cdr;
  logic [DATA_WIDTH-1:0] r_rsp_car;
  logic [DATA_WIDTH-1:0] r_rsp_cdr;
  logic [ADDR_WIDTH-1:0] w_addr_odd;
  logic                  w_accept;
  logic                  w_unused_addr_lsb;

  // The cdr word is formed by setting bit 0, so the top cell never wraps to word 0.
  assign w_addr_odd        = {r_addr[ADDR_WIDTH-1:1], 1'b1};
  assign w_accept          = (r_state == IDLE) && req_valid;
  assign w_unused_addr_lsb = req_addr[0];
  assign rsp_car           = r_rsp_car;
  assign rsp_cdr           = r_rsp_cdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Boot indication may be a single-cycle pulse, so remember it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_boot_seen <= 1'b0;
    end else if (mem_boot_done) begin
      r_boot_seen <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_BOOT: if (mem_boot_done || r_boot_seen) w_next_state = IDLE;
      IDLE:      if (req_valid) w_next_state = (cell_op_t'(req_op) == CELL_WRITE) ? WR_CAR : RD_CAR;
      RD_CAR:    w_next_state = RD_CDR;
      RD_CDR:    w_next_state = RD_CAP;
      RD_CAP:    w_next_state = RESP;
      WR_CAR:    w_next_state = WR_CDR;
      WR_CDR:    w_next_state = RESP;
      RESP:      if (rsp_ready) w_next_state = IDLE;
      default:   w_next_state = WAIT_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= CELL_READ;
      r_addr    <= '0;
      r_car     <= '0;
      r_cdr     <= '0;
      r_rsp_car <= '0;
      r_rsp_cdr <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= cell_op_t'(req_op);
        r_addr <= {req_addr[ADDR_WIDTH-1:1], 1'b0};
        r_car  <= req_car;
        r_cdr  <= req_cdr;
      end
      // Read data arrives one cycle after its address, hence the one-state skew.
      case (r_state)
        RD_CDR: r_rsp_car <= mem_read_data;
        RD_CAP: r_rsp_cdr <= mem_read_data;
        WR_CDR: begin
          r_rsp_car <= r_car;
          r_rsp_cdr <= r_cdr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_write_enable = 1'b0;
    mem_addr         = r_addr;
    mem_write_data   = '0;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    busy             = 1'b1;
    case (r_state)
      WAIT_BOOT: begin
        mem_addr = '0;
        busy     = 1'b0;
      end
      IDLE: begin
        mem_addr  = '0;
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      RD_CDR: mem_addr = w_addr_odd;
      WR_CAR: begin
        mem_write_enable = (r_op == CELL_WRITE);
        mem_write_data   = r_car;
      end
      WR_CDR: begin
        mem_write_enable = (r_op == CELL_WRITE);
        mem_addr         = w_addr_odd;
        mem_write_data   = r_cdr;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cons_cell_port.sv
// Directed bench for cons_cell_port with a behavioural RAM and a response scoreboard.
// Expected responses come from a shadow copy of memory kept by the stimulus tasks.
module tb_cons_cell_port;
  import cons_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] car;
    logic [DW-1:0] cdr;
  } rsp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          memBootDone;
  logic          memWriteEnable;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWriteData;
  logic [DW-1:0] memReadData;
  logic          reqValid;
  logic          reqReady;
  logic          reqOp;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqCar;
  logic [DW-1:0] reqCdr;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspCar;
  logic [DW-1:0] rspCdr;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            cycleCount = 0;
  rsp_t          sbQ[$];
  wr_t           wrLog[$];
  logic [DW-1:0] ram[256];
  logic [DW-1:0] shadow[256];
  bit            ramLoaded = 1'b0;

  always #5 clk = ~clk;

  cons_cell_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_boot_done    (memBootDone),
    .mem_write_enable (memWriteEnable),
    .mem_addr         (memAddr),
    .mem_write_data   (memWriteData),
    .mem_read_data    (memReadData),
    .req_valid        (reqValid),
    .req_ready        (reqReady),
    .req_op           (reqOp),
    .req_addr         (reqAddr),
    .req_car          (reqCar),
    .req_cdr          (reqCdr),
    .rsp_valid        (rspValid),
    .rsp_ready        (rspReady),
    .rsp_car          (rspCar),
    .rsp_cdr          (rspCdr),
    .busy             (busy)
  );

  function automatic logic [DW-1:0] pattern(input int i);
    return 16'(32'hA500 + i * 7);
  endfunction

  // Controller stand-in: synchronous-read RAM that logs every write strobe.
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
      ramLoaded <= 1'b1;
    end else if (memWriteEnable === 1'b1) begin
      ram[memAddr] <= memWriteData;
      wrLog.push_back({memAddr, memWriteData});
    end
    memReadData <= ram[memAddr];
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request from a negedge, waits for acceptance, records the expected response.
  task automatic applyStimulus(input logic op, input logic [AW-1:0] addr, input logic [DW-1:0] car,
                               input logic [DW-1:0] cdr, output int waited, output int acceptCycle);
    logic [AW-1:0] a;
    a        = {addr[AW-1:1], 1'b0};
    reqOp    = op;
    reqAddr  = addr;
    reqCar   = car;
    reqCdr   = cdr;
    reqValid = 1'b1;
    waited   = 0;
    while (reqReady !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (reqReady !== 1'b1) checkOutput("acceptTimeout", {31'b0, reqReady}, 32'd1);
    acceptCycle = cycleCount;
    if (op) begin
      sbQ.push_back({car, cdr});
      shadow[a]         = car;
      shadow[a | 8'h01] = cdr;
    end else begin
      sbQ.push_back({shadow[a], shadow[a | 8'h01]});
    end
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; checks latency, data, and hold behaviour.
  task automatic waitResponse(input string tag, input int expLatency, input int holdCycles);
    int   lat;
    rsp_t exp;
    lat = 0;
    while (rspValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "Latency"}, lat, expLatency);
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
    end else begin
      exp = '0;
      checkOutput({tag, "ScoreboardEmpty"}, 0, 1);
    end
    checkOutput({tag, "Car"}, rspCar, exp.car);
    checkOutput({tag, "Cdr"}, rspCdr, exp.cdr);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "HoldValid"}, rspValid, 1);
      checkOutput({tag, "HoldCar"}, rspCar, exp.car);
      checkOutput({tag, "HoldCdr"}, rspCdr, exp.cdr);
      checkOutput({tag, "HoldReqReady"}, reqReady, 0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput({tag, "ValidDrop"}, rspValid, 0);
    checkOutput({tag, "BackToIdle"}, reqReady, 1);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t entry;
    entry = (idx < wrLog.size()) ? wrLog[idx] : 'x;
    checkOutput({tag, "Addr"}, entry.addr, addr);
    checkOutput({tag, "Data"}, entry.data, data);
  endtask

  initial begin
    int waited;
    int acc[3];
    int base;

    for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
    rst         = 1'b1;
    memBootDone = 1'b0;
    reqValid    = 1'b0;
    reqOp       = 1'b0;
    reqAddr     = '0;
    reqCar      = '0;
    reqCdr      = '0;
    rspReady    = 1'b1;

    @(negedge clk);
    checkOutput("rstReqReady", reqReady, 0);
    checkOutput("rstRspValid", rspValid, 0);
    checkOutput("rstWe", memWriteEnable, 0);
    checkOutput("rstAddr", memAddr, 0);
    checkOutput("rstWdata", memWriteData, 0);
    checkOutput("rstRspCar", rspCar, 0);
    checkOutput("rstRspCdr", rspCdr, 0);
    checkOutput("rstBusy", busy, 0);
    rst = 1'b0;

    // Request held pending before boot; one-cycle boot pulse releases it.
    reqValid = 1'b1;
    reqOp    = 1'b0;
    reqAddr  = 8'h10;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      checkOutput("preBootReqReady", reqReady, 0);
      checkOutput("preBootAddr", memAddr, 0);
    end
    memBootDone = 1'b1;
    @(negedge clk);
    memBootDone = 1'b0;
    applyStimulus(1'b0, 8'h10, 16'h0, 16'h0, waited, acc[0]);
    checkOutput("bootAcceptWait", waited, 0);
    checkOutput("bootBusy", busy, 1);
    waitResponse("bootRead", 3, 0);

    base = wrLog.size();
    applyStimulus(1'b1, 8'h10, 16'hBEEF, 16'h1234, waited, acc[0]);
    waitResponse("write10", 2, 0);
    checkOutput("write10Count", wrLog.size() - base, 2);
    checkWrite("write10Car", base, 8'h10, 16'hBEEF);
    checkWrite("write10Cdr", base + 1, 8'h11, 16'h1234);

    applyStimulus(1'b0, 8'h10, 16'h0, 16'h0, waited, acc[0]);
    waitResponse("read10", 3, 0);

    base = wrLog.size();
    applyStimulus(1'b1, 8'hFF, 16'h1111, 16'h2222, waited, acc[0]);
    waitResponse("writeTop", 2, 0);
    checkOutput("writeTopCount", wrLog.size() - base, 2);
    checkWrite("writeTopCar", base, 8'hFE, 16'h1111);
    checkWrite("writeTopCdr", base + 1, 8'hFF, 16'h2222);
    applyStimulus(1'b0, 8'hFF, 16'h0, 16'h0, waited, acc[0]);
    waitResponse("readTop", 3, 0);
    applyStimulus(1'b0, 8'h00, 16'h0, 16'h0, waited, acc[0]);
    waitResponse("readZeroUntouched", 3, 0);

    rspReady = 1'b0;
    applyStimulus(1'b0, 8'h10, 16'h0, 16'h0, waited, acc[0]);
    waitResponse("backpressure", 3, 6);
    applyStimulus(1'b0, 8'h02, 16'h0, 16'h0, waited, acc[0]);
    checkOutput("postBackpressureWait", waited, 0);
    waitResponse("postBackpressure", 3, 0);

    // Reset lands in WR_CDR: car already written, cdr never written.
    applyStimulus(1'b1, 8'h20, 16'hAAAA, 16'h5555, waited, acc[0]);
    @(negedge clk);
    checkOutput("midWriteWe", memWriteEnable, 1);
    checkOutput("midWriteAddr", memAddr, 8'h21);
    checkOutput("midWriteBusy", busy, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("asyncRstWe", memWriteEnable, 0);
    checkOutput("asyncRstRspValid", rspValid, 0);
    checkOutput("asyncRstReqReady", reqReady, 0);
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstAddr", memAddr, 0);
    void'(sbQ.pop_back());
    shadow[8'h21] = pattern(8'h21);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rebootGate", reqReady, 0);
    end
    memBootDone = 1'b1;
    @(negedge clk);
    memBootDone = 1'b0;
    checkOutput("rebootIdle", reqReady, 1);
    applyStimulus(1'b0, 8'h20, 16'h0, 16'h0, waited, acc[0]);
    waitResponse("partialCell", 3, 0);

    rspReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'(k * 2), 16'h0, 16'h0, waited, acc[k]);
      waitResponse("b2bRead", 3, 0);
    end
    checkOutput("b2bSpacing01", acc[1] - acc[0], 5);
    checkOutput("b2bSpacing12", acc[2] - acc[1], 5);
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
